// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-master LSU arbiter: FSM states, master ids,
// access-size encodings and the per-master request bundle.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic master_id_t;

    // Word accesses are any op with op[1] = 0.
    localparam logic [1:0] LSU_OP_HALF = 2'b10;
    localparam logic [1:0] LSU_OP_BYTE = 2'b11;

    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  op;
        logic        ld_un;
    } lsu_req_t;

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; a live lock keeps the previous
// winner, otherwise a tie goes to the master not granted last.
module rr_arb2
    import lsu_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  master_id_t i_last_gnt,
    input  logic       i_lock_active,
    output master_id_t o_winner
);

    always_comb begin
        o_winner = 1'b0;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = i_lock_active ? i_last_gnt : ~i_last_gnt;
            default: o_winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates the CPU data port and a secondary master onto the single LSU
// port: one registered access cycle, then a done pulse with read data.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [1:0]  i_m0_op,
    input  logic        i_m0_ld_un,
    input  logic        i_m0_lock,
    output logic        o_m0_gnt,
    output logic        o_m0_done,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [1:0]  i_m1_op,
    input  logic        i_m1_ld_un,
    input  logic        i_m1_lock,
    output logic        o_m1_gnt,
    output logic        o_m1_done,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic        o_lsu_wren,
    output logic [1:0]  o_lsu_op,
    output logic        o_ld_un,
    input  logic [31:0] i_ld_data,
    output logic        o_busy
);

    state_t     r_state, w_next_state;
    master_id_t r_last_gnt, w_winner;
    logic       r_last_lock;
    logic [3:0] r_hold_cnt;
    logic [1:0] w_req_vec;
    logic       w_lock_active, w_grant_en, w_access_end, w_win_lock;
    lsu_req_t   w_req0, w_req1, w_win_req;

    assign w_req_vec = {i_m1_req, i_m0_req};
    assign w_req0    = '{wren: i_m0_wren, addr: i_m0_addr, wdata: i_m0_wdata,
                         op: i_m0_op, ld_un: i_m0_ld_un};
    assign w_req1    = '{wren: i_m1_wren, addr: i_m1_addr, wdata: i_m1_wdata,
                         op: i_m1_op, ld_un: i_m1_ld_un};
    assign w_win_req  = w_winner ? w_req1 : w_req0;
    assign w_win_lock = w_winner ? i_m1_lock : i_m0_lock;

    // The lock only survives while its owner keeps asking and has budget left.
    assign w_lock_active = r_last_lock && w_req_vec[r_last_gnt]
                           && (r_hold_cnt < 4'(HOLD_MAX));

    rr_arb2 u_rr_arb2 (
        .i_req         (w_req_vec),
        .i_last_gnt    (r_last_gnt),
        .i_lock_active (w_lock_active),
        .o_winner      (w_winner)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = (|w_req_vec) ? ACCESS : IDLE;
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = (|w_req_vec) ? ACCESS : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE and RESP, never during ACCESS.
    always_comb begin
        w_grant_en   = (r_state == IDLE || r_state == RESP) && (|w_req_vec);
        w_access_end = (r_state == ACCESS);
        o_busy       = (r_state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_last_gnt  <= 1'b1;
            r_last_lock <= 1'b0;
            r_hold_cnt  <= 4'd0;
        end else if (w_grant_en) begin
            r_last_gnt  <= w_winner;
            r_last_lock <= w_win_lock;
            if (w_winner != r_last_gnt)
                r_hold_cnt <= 4'd1;
            else if (r_hold_cnt < 4'(HOLD_MAX))
                r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    // LSU fields are latched at grant and held; wren is live for ACCESS only.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_m0_gnt   <= 1'b0;
            o_m1_gnt   <= 1'b0;
            o_m0_done  <= 1'b0;
            o_m1_done  <= 1'b0;
            o_m0_rdata <= 32'd0;
            o_m1_rdata <= 32'd0;
            o_lsu_addr <= 32'd0;
            o_st_data  <= 32'd0;
            o_lsu_wren <= 1'b0;
            o_lsu_op   <= 2'd0;
            o_ld_un    <= 1'b0;
        end else begin
            o_m0_gnt   <= w_grant_en && !w_winner;
            o_m1_gnt   <= w_grant_en && w_winner;
            o_m0_done  <= w_access_end && !r_last_gnt;
            o_m1_done  <= w_access_end && r_last_gnt;
            o_lsu_wren <= w_grant_en && w_win_req.wren;
            if (w_grant_en) begin
                o_lsu_addr <= w_win_req.addr;
                o_st_data  <= w_win_req.wdata;
                o_lsu_op   <= w_win_req.op;
                o_ld_un    <= w_win_req.ld_un;
            end
            if (w_access_end && !o_lsu_wren) begin
                if (r_last_gnt) o_m1_rdata <= i_ld_data;
                else            o_m0_rdata <= i_ld_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with a small word memory plus a switch
// register standing in for the LSU (extension done on the LSU side).
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam logic [31:0] SWITCHES = 32'h8000_0000;

    logic        i_clk, i_reset;
    logic        i_m0_req, i_m0_wren, i_m0_ld_un, i_m0_lock;
    logic [31:0] i_m0_addr, i_m0_wdata;
    logic [1:0]  i_m0_op;
    logic        i_m1_req, i_m1_wren, i_m1_ld_un, i_m1_lock;
    logic [31:0] i_m1_addr, i_m1_wdata;
    logic [1:0]  i_m1_op;
    logic        o_m0_gnt, o_m0_done, o_m1_gnt, o_m1_done;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_lsu_addr, o_st_data, i_ld_data;
    logic        o_lsu_wren, o_ld_un, o_busy;
    logic [1:0]  o_lsu_op;
    logic [31:0] mem [0:63];
    int          compared = 0;
    int          mismatched = 0;

    lsu_arbiter #(.HOLD_MAX(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_req(i_m0_req), .i_m0_wren(i_m0_wren), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_op(i_m0_op), .i_m0_ld_un(i_m0_ld_un),
        .i_m0_lock(i_m0_lock), .o_m0_gnt(o_m0_gnt), .o_m0_done(o_m0_done),
        .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_wren(i_m1_wren), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_op(i_m1_op), .i_m1_ld_un(i_m1_ld_un),
        .i_m1_lock(i_m1_lock), .o_m1_gnt(o_m1_gnt), .o_m1_done(o_m1_done),
        .o_m1_rdata(o_m1_rdata),
        .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren),
        .o_lsu_op(o_lsu_op), .o_ld_un(o_ld_un), .i_ld_data(i_ld_data),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] lsuExtend(input logic [31:0] word, input logic [1:0] bsel,
                                              input logic [1:0] op, input logic un);
        logic [31:0] sh;
        logic [15:0] h;
        sh = word >> {bsel, 3'b000};
        h  = bsel[1] ? word[31:16] : word[15:0];
        if (op == LSU_OP_BYTE) return un ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        if (op == LSU_OP_HALF) return un ? {16'd0, h} : {{16{h[15]}}, h};
        return word;
    endfunction

    // The LSU commits a store on the rising edge that ends ACCESS.
    always @(posedge i_clk) if (o_lsu_wren) mem[o_lsu_addr[7:2]] <= o_st_data;

    assign i_ld_data = lsuExtend((o_lsu_addr[31:16] == 16'h1001) ? SWITCHES : mem[o_lsu_addr[7:2]],
                                 o_lsu_addr[1:0], o_lsu_op, o_ld_un);

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic req, input logic wren,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] op, input logic ldUn, input logic lock);
        if (!m) begin
            i_m0_req = req; i_m0_wren = wren; i_m0_addr = addr; i_m0_wdata = wdata;
            i_m0_op = op; i_m0_ld_un = ldUn; i_m0_lock = lock;
        end else begin
            i_m1_req = req; i_m1_wren = wren; i_m1_addr = addr; i_m1_wdata = wdata;
            i_m1_op = op; i_m1_ld_un = ldUn; i_m1_lock = lock;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        int altSeq[4];
        int lockSeq[6];
        altSeq  = '{0, 1, 0, 1};
        lockSeq = '{0, 1, 1, 1, 1, 0};

        i_reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst gnt0",  32'(o_m0_gnt), 32'd0);
        checkOutput("rst done1", 32'(o_m1_done), 32'd0);
        checkOutput("rst wren",  32'(o_lsu_wren), 32'd0);
        checkOutput("rst addr",  o_lsu_addr, 32'd0);
        checkOutput("rst busy",  32'(o_busy), 32'd0);
        checkOutput("rst rdata0", o_m0_rdata, 32'd0);
        i_reset = 1'b1;
        tick();

        // Word store, then a load of the same address re-armed during ACCESS.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("st gnt0", 32'(o_m0_gnt), 32'd1);
        checkOutput("st gnt1", 32'(o_m1_gnt), 32'd0);
        checkOutput("st wren", 32'(o_lsu_wren), 32'd1);
        checkOutput("st addr", o_lsu_addr, 32'h100);
        checkOutput("st data", o_st_data, 32'hDEAD_BEEF);
        checkOutput("st busy", 32'(o_busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("st done0", 32'(o_m0_done), 32'd1);
        checkOutput("st wren resp", 32'(o_lsu_wren), 32'd0);
        checkOutput("st gnt0 resp", 32'(o_m0_gnt), 32'd0);
        tick();
        checkOutput("ld gnt0", 32'(o_m0_gnt), 32'd1);
        checkOutput("ld wren", 32'(o_lsu_wren), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("ld done0", 32'(o_m0_done), 32'd1);
        checkOutput("ld rdata0", o_m0_rdata, 32'hDEAD_BEEF);
        tick();
        checkOutput("idle busy", 32'(o_busy), 32'd0);
        checkOutput("idle done0", 32'(o_m0_done), 32'd0);

        // Signed then unsigned byte load of the top switch byte.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1001_0003, 32'd0, 2'b11, 1'b0, 1'b0);
        tick();
        checkOutput("sb gnt0", 32'(o_m0_gnt), 32'd1);
        checkOutput("sb op", 32'(o_lsu_op), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1001_0003, 32'd0, 2'b11, 1'b1, 1'b0);
        tick();
        checkOutput("sb rdata0", o_m0_rdata, 32'hFFFF_FF80);
        tick();
        checkOutput("ub ld_un", 32'(o_ld_un), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("ub rdata0", o_m0_rdata, 32'h0000_0080);
        checkOutput("ub rdata1 held", o_m1_rdata, 32'd0);
        tick();

        // Master 1 drops after its grant; master 0 follows back-to-back.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h1001_0000, 32'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("b2b gnt1", 32'(o_m1_gnt), 32'd1);
        checkOutput("b2b gnt0 off", 32'(o_m0_gnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("b2b done1", 32'(o_m1_done), 32'd1);
        checkOutput("b2b done0 off", 32'(o_m0_done), 32'd0);
        checkOutput("b2b rdata1", o_m1_rdata, 32'h8000_0000);
        tick();
        checkOutput("b2b gnt0", 32'(o_m0_gnt), 32'd1);
        checkOutput("b2b busy", 32'(o_busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("b2b done0", 32'(o_m0_done), 32'd1);
        checkOutput("b2b rdata0", o_m0_rdata, 32'hDEAD_BEEF);
        tick();

        // Reset in the middle of a store's ACCESS cycle.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h108, 32'hCAFE_F00D, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("abort wren", 32'(o_lsu_wren), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
        i_reset = 1'b0;
        tick();
        checkOutput("abort done0", 32'(o_m0_done), 32'd0);
        checkOutput("abort wren off", 32'(o_lsu_wren), 32'd0);
        checkOutput("abort busy", 32'(o_busy), 32'd0);
        checkOutput("abort addr", o_lsu_addr, 32'd0);
        checkOutput("abort rdata0", o_m0_rdata, 32'd0);
        i_reset = 1'b1;
        tick();

        // Both masters load continuously without lock: strict alternation from master 0.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h1001_0000, 32'd0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("alt gnt0", 32'(o_m0_gnt), 32'(altSeq[i] == 0));
            checkOutput("alt gnt1", 32'(o_m1_gnt), 32'(altSeq[i] == 1));
            if (i == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
                applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
            end
            tick();
            checkOutput("alt done", 32'(altSeq[i] == 0 ? o_m0_done : o_m1_done), 32'd1);
            checkOutput("alt gap gnt", 32'(o_m0_gnt | o_m1_gnt), 32'd0);
        end
        tick();

        // Master 1 holds its lock: four consecutive grants, then master 0.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h1001_0000, 32'd0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("lock gnt0", 32'(o_m0_gnt), 32'(lockSeq[i] == 0));
            checkOutput("lock gnt1", 32'(o_m1_gnt), 32'(lockSeq[i] == 1));
            if (i == 5) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
                applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
            end
            tick();
        end
        tick();
        checkOutput("end busy", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
